// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//
// Parametrised register file with NUM_GPR general registers (R1..Rn) and
// NUM_SCR scratch registers (S1..Sm). Each register is WIDTH bits wide.
// Every register whose active-low select bit is 0 applies the same FunSel
// operation on the rising clock edge. Two combinational read ports select
// registers by flat index: R1..Rn come first, then S1..Sm.
//
// A ClearAll pulse starts a sweep that clears one register per cycle, in index
// order. Busy is high while the sweep runs. Writes and further ClearAll pulses
// are ignored until the sweep finishes.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read port returns I in the same cycle if it selects an
//   enabled register while FunSel=010 and Busy=0.
//   When undefined, reads always return stored values.
//
// Ports
//   Clock    in   1        rising-edge clock
//   Reset    in   1        asynchronous active-low reset, clears everything
//   FunSel   in   3        operation applied to every enabled register
//   RegSel   in   NUM_GPR  active-low enables, MSB = R1, LSB = Rn
//   ScrSel   in   NUM_SCR  active-low enables, MSB = S1, LSB = Sm
//   I        in   WIDTH    write data
//   ClearAll in   1        single-cycle pulse that starts the clear sweep
//   OutASel  in   SELW     read index for port A
//   OutBSel  in   SELW     read index for port B
//   OutA     out  WIDTH    combinational read data for port A
//   OutB     out  WIDTH    combinational read data for port B
//   Busy     out  1        high while the clear sweep is active
// -----------------------------------------------------------------------------
module param_register_file #(
  parameter  int WIDTH    = 16,
  parameter  int NUM_GPR  = 4,
  parameter  int NUM_SCR  = 4,
  localparam int NUM_REGS = NUM_GPR + NUM_SCR,
  localparam int SELW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  // A zero-width port is not legal, so a single unused bit stands in when
  // there are no scratch registers.
  localparam int SCR_W    = (NUM_SCR > 0) ? NUM_SCR : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       FunSel,
  input  logic [NUM_GPR-1:0] RegSel,
  input  logic [SCR_W-1:0] ScrSel,
  input  logic [WIDTH-1:0] I,
  input  logic             ClearAll,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Busy
);

  localparam int HALF = WIDTH / 2;
  localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_REGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] rd_val [NUM_REGS];
  logic [NUM_REGS-1:0] en;
  logic            busy;

  // Result of one FunSel operation on a single register.
  // H is the upper half of the register, L is the lower half of I.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       fsel,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] din
  );
    logic [HALF-1:0] il;
    il = din[HALF-1:0];
    unique case (fsel)
      3'b000: apply_op = q - WIDTH'(1);
      3'b001: apply_op = q + WIDTH'(1);
      3'b010: apply_op = din;
      3'b011: apply_op = '0;
      3'b100: apply_op = {{(WIDTH-HALF){1'b0}}, il};
      3'b101: apply_op = {q[WIDTH-1:HALF], il};
      3'b110: apply_op = {il, q[HALF-1:0]};
      default: apply_op = {{(WIDTH-HALF){il[HALF-1]}}, il};
    endcase
  endfunction

  // Flatten the two select buses into one enable per register index.
  // The select buses list the first register at the MSB, so the bit order
  // is reversed here.
  always_comb begin
    en = '0;
    for (int k = 0; k < NUM_GPR; k++) begin
      en[k] = ~RegSel[NUM_GPR-1-k];
    end
    for (int k = 0; k < NUM_SCR; k++) begin
      en[NUM_GPR+k] = ~ScrSel[NUM_SCR-1-k];
    end
  end

  assign busy = (state_q == SWEEP);
  assign Busy = busy;

  // Next-state logic for the sweep FSM and the register contents.
  // In IDLE, writes and a ClearAll pulse on the same edge are both honoured.
  // The write lands first, and then the sweep begins. In SWEEP, only the
  // register at the current index changes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end

    unique case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (en[k]) begin
            regs_d[k] = apply_op(FunSel, regs_q[k], I);
          end
        end
        if (ClearAll) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (idx_q == SELW'(k)) begin
            regs_d[k] = '0;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + SELW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, index and register storage with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Per-register read value. With the bypass enabled, a plain load
  // (FunSel=010) is forwarded to the read ports in the same cycle. This
  // happens only outside the sweep, because writes are dropped during it.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_val[k] = regs_q[k];
`ifdef REGFILE_BYPASS_EN
      if (en[k] && (FunSel == 3'b010) && !busy) begin
        rd_val[k] = I;
      end
`endif
    end
  end

  // Read multiplexers. An index with no matching register leaves the
  // default of zero in place.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SELW'(k)) begin
        OutA = rd_val[k];
      end
      if (OutBSel == SELW'(k)) begin
        OutB = rd_val[k];
      end
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
//
// Directed bench for param_register_file with WIDTH=16, NUM_GPR=4 and
// NUM_SCR=4. The register contents are modelled as a plain array. The clear
// sweep is modelled as a queue of register indices still to be cleared.
// A compare process checks OutA, OutB and Busy against the model on every
// falling edge. The stimulus sequence also checks hand-computed literal
// values at key points.
// -----------------------------------------------------------------------------
module tb_param_register_file;

  logic        Clock;
  logic        Reset;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [15:0] I;
  logic        ClearAll;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [15:0] OutA;
  logic [15:0] OutB;
  logic        Busy;

  int compared   = 0;
  int mismatched = 0;
  bit started    = 0;

  logic [15:0] m_regs [8];
  int          sweep_q [$];

  param_register_file #(
    .WIDTH   (16),
    .NUM_GPR (4),
    .NUM_SCR (4)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .FunSel   (FunSel),
    .RegSel   (RegSel),
    .ScrSel   (ScrSel),
    .I        (I),
    .ClearAll (ClearAll),
    .OutASel  (OutASel),
    .OutBSel  (OutBSel),
    .OutA     (OutA),
    .OutB     (OutB),
    .Busy     (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Registers 0..3 are R1..R4, controlled by RegSel bits 3..0.
  // Registers 4..7 are S1..S4, controlled by ScrSel bits 3..0.
  function automatic bit enabled(input int k);
    if (k < 4) enabled = !RegSel[3-k];
    else       enabled = !ScrSel[7-k];
  endfunction

  function automatic logic [15:0] model_op(input logic [2:0] f,
                                           input logic [15:0] q,
                                           input logic [15:0] d);
    int lo;
    lo = int'(d) & 'hFF;
    case (f)
      3'd0: model_op = 16'((int'(q) + 65535) % 65536);
      3'd1: model_op = 16'((int'(q) + 1) % 65536);
      3'd2: model_op = d;
      3'd3: model_op = 16'h0000;
      3'd4: model_op = 16'(lo);
      3'd5: model_op = 16'((int'(q) & 'hFF00) | lo);
      3'd6: model_op = 16'((lo * 256) | (int'(q) & 'hFF));
      default: model_op = (lo >= 128) ? 16'('hFF00 | lo) : 16'(lo);
    endcase
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] sel);
    int k;
    k = int'(sel);
    exp_read = m_regs[k];
`ifdef REGFILE_BYPASS_EN
    if (enabled(k) && (FunSel == 3'b010) && (sweep_q.size() == 0)) exp_read = I;
`endif
  endfunction

  // Model of the register file. The queue holds the indices still to be
  // cleared, so a non-empty queue means the file is busy.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < 8; k++) m_regs[k] = 16'h0000;
      sweep_q.delete();
    end else if (sweep_q.size() != 0) begin
      m_regs[sweep_q.pop_front()] = 16'h0000;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (enabled(k)) m_regs[k] = model_op(FunSel, m_regs[k], I);
      end
      if (ClearAll) begin
        for (int k = 0; k < 8; k++) sweep_q.push_back(k);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process against the model on every falling edge.
  always @(negedge Clock) begin
    if (started) begin
      checkOutput("cyc_outa", 32'(OutA), 32'(exp_read(OutASel)));
      checkOutput("cyc_outb", 32'(OutB), 32'(exp_read(OutBSel)));
      checkOutput("cyc_busy", 32'(Busy), 32'(sweep_q.size() != 0));
    end
  end

  task automatic drive(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] f,
                       input logic [15:0] d, input logic clr, input logic [2:0] asel,
                       input logic [2:0] bsel);
    RegSel   = rs;
    ScrSel   = ss;
    FunSel   = f;
    I        = d;
    ClearAll = clr;
    OutASel  = asel;
    OutBSel  = bsel;
  endtask

  // Inputs change shortly after a rising edge. They take effect on the
  // following rising edge.
  task automatic applyStimulus(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] f,
                               input logic [15:0] d, input logic clr, input logic [2:0] asel,
                               input logic [2:0] bsel);
    @(posedge Clock);
    #2;
    drive(rs, ss, f, d, clr, asel, bsel);
  endtask

  task automatic idleRead(input logic [2:0] asel, input logic [2:0] bsel);
    applyStimulus(4'hF, 4'hF, 3'b000, 16'h0000, 1'b0, asel, bsel);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    Reset = 1'b1;
    drive(4'hF, 4'hF, 3'b000, 16'h0000, 1'b0, 3'd0, 3'd1);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b1;
    started = 1;
    #1;
    checkOutput("reset_outa", 32'(OutA), 32'h0);
    checkOutput("reset_busy", 32'(Busy), 32'h0);

    // Load several registers, then reset between clock edges.
    applyStimulus(4'b0000, 4'b0000, 3'b010, 16'hA5A5, 1'b0, 3'd0, 3'd7);
    idleRead(3'd0, 3'd7);
    checkOutput("preload_outa", 32'(OutA), 32'hA5A5);
    #1 Reset = 1'b0;
    #1;
    checkOutput("async_reset_outa", 32'(OutA), 32'h0);
    checkOutput("async_reset_outb", 32'(OutB), 32'h0);
    checkOutput("async_reset_busy", 32'(Busy), 32'h0);
    @(posedge Clock);
    #2 Reset = 1'b1;

    // Load R1 only, then check that R2 is untouched.
    applyStimulus(4'b0111, 4'hF, 3'b010, 16'h1234, 1'b0, 3'd0, 3'd1);
    idleRead(3'd0, 3'd1);
    checkOutput("r1_load", 32'(OutA), 32'h1234);
    checkOutput("r2_untouched", 32'(OutB), 32'h0);

    // Check increment and decrement wrap-around on R3.
    applyStimulus(4'b1101, 4'hF, 3'b010, 16'hFFFF, 1'b0, 3'd2, 3'd0);
    applyStimulus(4'b1101, 4'hF, 3'b001, 16'h0000, 1'b0, 3'd2, 3'd0);
    idleRead(3'd2, 3'd0);
    checkOutput("r3_inc_wrap", 32'(OutA), 32'h0000);
    applyStimulus(4'b1101, 4'hF, 3'b000, 16'h0000, 1'b0, 3'd2, 3'd0);
    idleRead(3'd2, 3'd0);
    checkOutput("r3_dec_wrap", 32'(OutA), 32'hFFFF);

    // Check sign extension of the low half of I on R1.
    applyStimulus(4'b0111, 4'hF, 3'b010, 16'hAB00, 1'b0, 3'd0, 3'd2);
    applyStimulus(4'b0111, 4'hF, 3'b111, 16'h0080, 1'b0, 3'd0, 3'd2);
    idleRead(3'd0, 3'd2);
    checkOutput("r1_sext", 32'(OutA), 32'hFF80);

    // Check the half-word operations on R2.
    applyStimulus(4'b1011, 4'hF, 3'b010, 16'h1234, 1'b0, 3'd1, 3'd0);
    applyStimulus(4'b1011, 4'hF, 3'b101, 16'h00CD, 1'b0, 3'd1, 3'd0);
    idleRead(3'd1, 3'd0);
    checkOutput("r2_keep_high", 32'(OutA), 32'h12CD);
    applyStimulus(4'b1011, 4'hF, 3'b110, 16'h0077, 1'b0, 3'd1, 3'd0);
    idleRead(3'd1, 3'd0);
    checkOutput("r2_low_to_high", 32'(OutA), 32'h77CD);
    applyStimulus(4'b1011, 4'hF, 3'b100, 16'hAB99, 1'b0, 3'd1, 3'd0);
    idleRead(3'd1, 3'd0);
    checkOutput("r2_zero_ext", 32'(OutA), 32'h0099);
    applyStimulus(4'b1011, 4'hF, 3'b111, 16'h0012, 1'b0, 3'd1, 3'd0);
    idleRead(3'd1, 3'd0);
    checkOutput("r2_sext_pos", 32'(OutA), 32'h0012);
    applyStimulus(4'b1011, 4'hF, 3'b011, 16'hFFFF, 1'b0, 3'd1, 3'd0);
    idleRead(3'd1, 3'd0);
    checkOutput("r2_clear", 32'(OutA), 32'h0000);

    // With every select bit high, no register may change.
    applyStimulus(4'hF, 4'hF, 3'b010, 16'hDEAD, 1'b0, 3'd0, 3'd2);
    idleRead(3'd0, 3'd2);
    checkOutput("nosel_r1", 32'(OutA), 32'hFF80);
    checkOutput("nosel_r3", 32'(OutB), 32'hFFFF);

    // Load every register, then start a sweep on the same edge as a write
    // to S4. Try to write during the sweep as well.
    applyStimulus(4'b0000, 4'b0000, 3'b010, 16'h5555, 1'b0, 3'd0, 3'd7);
    idleRead(3'd3, 3'd4);
    checkOutput("all_5555_r4", 32'(OutA), 32'h5555);
    checkOutput("all_5555_s1", 32'(OutB), 32'h5555);
    applyStimulus(4'hF, 4'b1110, 3'b010, 16'h7777, 1'b1, 3'd0, 3'd7);
    @(posedge Clock);
    #2;
    cnt = 0;
    for (int c = 0; c < 20 && Busy; c++) begin
      cnt++;
      if (c < 3) drive(4'b0000, 4'b0000, 3'b010, 16'hFFFF, 1'b0, 3'd0, 3'd7);
      else       drive(4'hF, 4'hF, 3'b000, 16'h0000, 1'b0, 3'd0, 3'd7);
      @(posedge Clock);
      #2;
    end
    checkOutput("sweep_busy_cycles", 32'(cnt), 32'd8);
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 4'hF, 3'b000, 16'h0000, 1'b0, 3'(k), 3'(7 - k));
      #1;
      checkOutput("sweep_cleared", 32'(OutA), 32'h0);
    end

    // Reset in the middle of a sweep.
    applyStimulus(4'b0000, 4'b0000, 3'b010, 16'h3C3C, 1'b0, 3'd0, 3'd7);
    applyStimulus(4'hF, 4'hF, 3'b000, 16'h0000, 1'b1, 3'd6, 3'd7);
    applyStimulus(4'hF, 4'hF, 3'b000, 16'h0000, 1'b0, 3'd6, 3'd7);
    applyStimulus(4'hF, 4'hF, 3'b000, 16'h0000, 1'b0, 3'd6, 3'd7);
    applyStimulus(4'hF, 4'hF, 3'b000, 16'h0000, 1'b0, 3'd6, 3'd7);
    #1;
    checkOutput("midsweep_busy_before", 32'(Busy), 32'h1);
    checkOutput("midsweep_s4_before", 32'(OutB), 32'h3C3C);
    Reset = 1'b0;
    #1;
    checkOutput("midsweep_reset_busy", 32'(Busy), 32'h0);
    checkOutput("midsweep_reset_s3", 32'(OutA), 32'h0);
    checkOutput("midsweep_reset_s4", 32'(OutB), 32'h0);
    @(posedge Clock);
    #2 Reset = 1'b1;
    idleRead(3'd6, 3'd7);
    checkOutput("idle_after_reset", 32'(Busy), 32'h0);

    // Same-cycle write-through on S2 (ScrSel=1011).
    applyStimulus(4'hF, 4'b1011, 3'b010, 16'h1111, 1'b0, 3'd0, 3'd5);
    applyStimulus(4'hF, 4'b1011, 3'b010, 16'hBEEF, 1'b0, 3'd0, 3'd5);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_s2", 32'(OutB), 32'hBEEF);
`else
    checkOutput("no_bypass_s2", 32'(OutB), 32'h1111);
`endif
    idleRead(3'd0, 3'd5);
    checkOutput("s2_stored", 32'(OutB), 32'hBEEF);
    applyStimulus(4'hF, 4'b1011, 3'b001, 16'h0000, 1'b0, 3'd0, 3'd5);
    #1;
    checkOutput("inc_not_bypassed", 32'(OutB), 32'hBEEF);
    idleRead(3'd0, 3'd5);
    checkOutput("s2_inc", 32'(OutB), 32'hBEF0);

    repeat (2) @(posedge Clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
